// File: rtl/coin_credit_fsm.sv
// coin_credit_fsm
//   Coin credit accumulator and vending sequencer. Coins add credit up to
//   MAX_CREDIT. A purchase deducts the selected slot price and pulses
//   dispense. Any remainder, or the full credit on cancel, is returned one
//   CHANGE_UNIT coin per cycle.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   enable        gates coin acceptance only
//   coin_valid    one-cycle strobe; moneda holds the coin code
//   moneda[1:0]   coin code 0..3 -> COIN_V0..COIN_V3
//   sel[1:0]      product slot, sampled with buy
//   buy, cancel   one-cycle purchase / refund requests
//   monto[W-1:0]  current credit
//   dispense      one-cycle product release
//   change_pulse  one-cycle release of one CHANGE_UNIT coin
//   coin_reject   one-cycle pulse; return the offered coin
//   insufficient  one-cycle pulse; buy refused
//   busy          high while dispensing or returning change
//   state_dbg     current FSM state (0 IDLE, 1 ACCUM, 2 DISPENSE, 3 CHANGE)
//
// Handshake: there is no backpressure. Every coin_valid strobe has exactly one
// outcome on the next cycle: the credit grows, or coin_reject pulses. buy and
// cancel are single-cycle requests with no acknowledge. While busy is high
// they are dropped silently.
module coin_credit_fsm #(
  parameter int W           = 12,
  parameter int COIN_V0     = 25,
  parameter int COIN_V1     = 50,
  parameter int COIN_V2     = 100,
  parameter int COIN_V3     = 500,
  parameter int PRICE0      = 75,
  parameter int PRICE1      = 150,
  parameter int PRICE2      = 300,
  parameter int PRICE3      = 1000,
  parameter int CHANGE_UNIT = 25,
  parameter int MAX_CREDIT  = 2000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         coin_valid,
  input  logic [1:0]   moneda,
  input  logic [1:0]   sel,
  input  logic         buy,
  input  logic         cancel,
  output logic [W-1:0] monto,
  output logic         dispense,
  output logic         change_pulse,
  output logic         coin_reject,
  output logic         insufficient,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCUM    = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  localparam logic [W-1:0] UNIT    = W'(CHANGE_UNIT);
  localparam logic [W:0]   MAX_EXT = (W+1)'(MAX_CREDIT);

  state_t       state, state_d;
  logic [W-1:0] monto_d;
  logic         dispense_d, change_pulse_d, coin_reject_d, insufficient_d;

  logic [W-1:0] coin_val;
  logic [W-1:0] price;
  logic [W:0]   coin_sum;
  logic         ready;
  logic         coin_ok;
  logic         buy_ok;

  always_comb begin
    case (moneda)
      2'b00:   coin_val = W'(COIN_V0);
      2'b01:   coin_val = W'(COIN_V1);
      2'b10:   coin_val = W'(COIN_V2);
      default: coin_val = W'(COIN_V3);
    endcase
  end

  always_comb begin
    case (sel)
      2'b00:   price = W'(PRICE0);
      2'b01:   price = W'(PRICE1);
      2'b10:   price = W'(PRICE2);
      default: price = W'(PRICE3);
    endcase
  end

  // One extra bit so the ceiling test cannot be fooled by a wrapped sum.
  assign coin_sum = {1'b0, monto} + {1'b0, coin_val};
  assign ready    = (state == S_IDLE) || (state == S_ACCUM);
  // A coin only counts when it is the sole request this cycle:
  // cancel and buy both outrank it.
  assign coin_ok  = coin_valid && enable && ready && !buy && !cancel &&
                    (coin_sum <= MAX_EXT);
  assign buy_ok   = buy && !cancel && (state == S_ACCUM) && (monto >= price);

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      monto        <= '0;
      dispense     <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
    end else begin
      state        <= state_d;
      monto        <= monto_d;
      dispense     <= dispense_d;
      change_pulse <= change_pulse_d;
      coin_reject  <= coin_reject_d;
      insufficient <= insufficient_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (coin_ok) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (cancel)      state_d = S_CHANGE;
        else if (buy_ok) state_d = S_DISPENSE;
      end
      S_DISPENSE: begin
        state_d = (monto != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        // Leave on the same edge that pays out the last unit coin.
        if (monto <= UNIT) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    monto_d        = monto;
    dispense_d     = 1'b0;
    change_pulse_d = 1'b0;
    coin_reject_d  = coin_valid && !coin_ok;
    insufficient_d = 1'b0;
    case (state)
      S_IDLE, S_ACCUM: begin
        if (cancel) begin
          // Refund keeps the full credit; CHANGE pays it out.
          monto_d = monto;
        end else if (buy) begin
          if (buy_ok) begin
            monto_d    = monto - price;
            dispense_d = 1'b1;
          end else begin
            insufficient_d = 1'b1;
          end
        end else if (coin_ok) begin
          monto_d = coin_sum[W-1:0];
        end
      end
      S_CHANGE: begin
        if (monto > UNIT) begin
          monto_d        = monto - UNIT;
          change_pulse_d = 1'b1;
        end else begin
          // Clamp at zero rather than wrap.
          monto_d        = '0;
          change_pulse_d = (monto != '0);
        end
      end
      default: begin
        monto_d = monto;
      end
    endcase
  end

  assign busy      = (state == S_DISPENSE) || (state == S_CHANGE);
  assign state_dbg = state;

endmodule

// File: tb/tb_coin_credit_fsm.sv
module tb_coin_credit_fsm;

  localparam int W = 12;
  localparam int UNIT = 25;
  localparam int MAXC = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         enable, coin_valid, buy, cancel;
  logic [1:0]   moneda, sel;
  logic [W-1:0] monto;
  logic         dispense, change_pulse, coin_reject, insufficient, busy;
  logic [1:0]   state_dbg;

  coin_credit_fsm dut (
    .clk(clk), .rst(rst), .enable(enable), .coin_valid(coin_valid),
    .moneda(moneda), .sel(sel), .buy(buy), .cancel(cancel),
    .monto(monto), .dispense(dispense), .change_pulse(change_pulse),
    .coin_reject(coin_reject), .insufficient(insufficient), .busy(busy),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Observed outputs packed for comparison and printing.
  logic [W+6:0] dut_v;
  assign dut_v = {monto, dispense, change_pulse, coin_reject, insufficient, busy, state_dbg};

  // ---------------- reference model ----------------
  // Current expected outputs, plus a script of expected future cycles that
  // is queued whenever a purchase or refund starts a multi-cycle payout.
  int e_monto;
  bit e_disp, e_pulse, e_rej, e_ins, e_busy;
  logic [W+2:0] exp_q[$];  // {busy, change_pulse, dispense, monto}

  function automatic int coin_value(input logic [1:0] c);
    case (c)
      2'b00:   return 25;
      2'b01:   return 50;
      2'b10:   return 100;
      default: return 500;
    endcase
  endfunction

  function automatic int price_of(input logic [1:0] s);
    case (s)
      2'b00:   return 75;
      2'b01:   return 150;
      2'b10:   return 300;
      default: return 1000;
    endcase
  endfunction

  function automatic logic [1:0] e_state();
    if (e_busy) return e_disp ? 2'd2 : 2'd3;
    return (e_monto > 0) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [W+6:0] exp_v();
    return {W'(e_monto), e_disp, e_pulse, e_rej, e_ins, e_busy, e_state()};
  endfunction

  function automatic logic [W+2:0] ent(input bit b, input bit p, input bit d, input int m);
    return {b, p, d, W'(m)};
  endfunction

  // Payout script: an optional dispense cycle, one cycle holding the amount,
  // then amt/UNIT pulses counting down to 0 (the last one already idle).
  task automatic push_payout(input int amt, input bit with_dispense);
    int n;
    if (with_dispense) exp_q.push_back(ent(1'b1, 1'b0, 1'b1, amt));
    if (amt == 0) begin
      exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 0));
    end else begin
      exp_q.push_back(ent(1'b1, 1'b0, 1'b0, amt));
      n = amt / UNIT;
      for (int k = n - 1; k >= 0; k--) exp_q.push_back(ent(k > 0, 1'b1, 1'b0, k * UNIT));
    end
  endtask

  task automatic pop_entry();
    logic [W+2:0] e;
    e = exp_q.pop_front();
    e_busy  = e[W+2];
    e_pulse = e[W+1];
    e_disp  = e[W];
    e_monto = int'(e[W-1:0]);
  endtask

  task automatic model_reset();
    exp_q.delete();
    e_monto = 0; e_disp = 0; e_pulse = 0; e_rej = 0; e_ins = 0; e_busy = 0;
  endtask

  // ---------------- driver ----------------
  // row = {coin_valid, moneda[1:0], enable, sel[1:0], buy, cancel}
  task automatic cycle(input logic [7:0] r);
    bit cv, en, b, c;
    logic [1:0] m, s;
    cv = r[7]; m = r[6:5]; en = r[4]; s = r[3:2]; b = r[1]; c = r[0];
    coin_valid = cv; moneda = m; enable = en; sel = s; buy = b; cancel = c;
    e_disp = 0; e_pulse = 0; e_rej = 0; e_ins = 0;
    if (exp_q.size() > 0) begin
      pop_entry();
      e_rej = cv;
    end else if (c) begin
      e_rej = cv;
      if (e_monto > 0) begin push_payout(e_monto, 1'b0); pop_entry(); end
    end else if (b) begin
      e_rej = cv;
      if (e_monto >= price_of(s)) begin
        push_payout(e_monto - price_of(s), 1'b1);
        pop_entry();
      end else begin
        e_ins = 1;
      end
    end else if (cv) begin
      if (en && (e_monto + coin_value(m) <= MAXC)) e_monto = e_monto + coin_value(m);
      else e_rej = 1;
    end
    @(posedge clk);
    #1;
    coin_valid = 1'b0; buy = 1'b0; cancel = 1'b0;
  endtask

  localparam logic [7:0] IDLE_R = 8'b0_00_1_00_0_0;

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_v !== '0) begin
      errors++; $display("FAIL reset_hold: got %h exp %h", dut_v, {(W+7){1'b0}});
    end
    rst = 1'b0;
    cycle(IDLE_R);
    checks++;
    if (dut_v !== exp_v()) begin
      errors++; $display("FAIL reset_idle: got %h exp %h", dut_v, exp_v());
    end
  endtask

  task automatic test_coins();
    logic [7:0] rows[$];
    int n_rej = 0;
    rows = '{8'b1_01_1_00_0_0, IDLE_R, 8'b1_01_1_00_0_0, IDLE_R,
             8'b1_01_1_00_0_0, IDLE_R, 8'b1_10_1_00_0_0, IDLE_R};
    foreach (rows[i]) begin
      cycle(rows[i]);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL coins row %0d: got %h exp %h", i, dut_v, exp_v());
      end
      if (coin_reject) n_rej++;
    end
    checks++;
    if (monto !== 12'd250 || state_dbg !== 2'd1 || n_rej != 0) begin
      errors++;
      $display("FAIL coins_total: got monto=%0d st=%0d rej=%0d exp monto=250 st=1 rej=0", monto, state_dbg, n_rej);
    end
  endtask

  task automatic test_buy_change();
    logic [7:0] rows[$];
    int n_pulse = 0, n_busy = 0, n_disp = 0;
    rows = '{8'b0_00_1_01_1_0, IDLE_R, IDLE_R, IDLE_R, IDLE_R, IDLE_R, IDLE_R};
    foreach (rows[i]) begin
      cycle(rows[i]);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL buy_change row %0d: got %h exp %h", i, dut_v, exp_v());
      end
      if (change_pulse) n_pulse++;
      if (busy) n_busy++;
      if (dispense) n_disp++;
    end
    checks++;
    if (n_pulse != 4 || n_busy != 5 || n_disp != 1 || monto !== '0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL buy_change_totals: got pulses=%0d busy=%0d disp=%0d monto=%0d exp 4 5 1 0",
               n_pulse, n_busy, n_disp, monto);
    end
  endtask

  task automatic test_insufficient();
    logic [7:0] rows[$];
    int n_ins = 0, n_disp = 0;
    rows = '{8'b1_10_1_00_0_0, IDLE_R, 8'b0_00_1_10_1_0, IDLE_R};
    foreach (rows[i]) begin
      cycle(rows[i]);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL insufficient row %0d: got %h exp %h", i, dut_v, exp_v());
      end
      if (insufficient) n_ins++;
      if (dispense) n_disp++;
    end
    checks++;
    if (n_ins != 1 || n_disp != 0 || monto !== 12'd100) begin
      errors++;
      $display("FAIL insufficient_totals: got ins=%0d disp=%0d monto=%0d exp 1 0 100", n_ins, n_disp, monto);
    end
  endtask

  task automatic test_ceiling();
    logic [7:0] rows[$];
    int n_rej = 0;
    // 100 + 3*500 + 3*100 = 1900, then 500 refused, then 100 reaches 2000.
    rows = '{8'b1_11_1_00_0_0, 8'b1_11_1_00_0_0, 8'b1_11_1_00_0_0,
             8'b1_10_1_00_0_0, 8'b1_10_1_00_0_0, 8'b1_10_1_00_0_0,
             8'b1_11_1_00_0_0, 8'b1_10_1_00_0_0};
    foreach (rows[i]) begin
      cycle(rows[i]);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL ceiling row %0d: got %h exp %h", i, dut_v, exp_v());
      end
      if (coin_reject) n_rej++;
    end
    checks++;
    if (monto !== 12'd2000 || n_rej != 1) begin
      errors++; $display("FAIL ceiling_total: got monto=%0d rej=%0d exp 2000 1", monto, n_rej);
    end
    // Refund the full ceiling: 80 back-to-back pulses.
    cycle(8'b0_00_1_00_0_1);
    for (int i = 0; i < 84; i++) begin
      cycle(IDLE_R);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL ceiling_drain cyc %0d: got %h exp %h", i, dut_v, exp_v());
      end
    end
  endtask

  task automatic test_cancel_coin();
    logic [7:0] rows[$];
    int n_rej = 0, n_pulse = 0;
    rows = '{8'b1_10_1_00_0_0, 8'b1_01_1_00_0_0, 8'b1_00_1_00_0_1,
             IDLE_R, IDLE_R, IDLE_R, IDLE_R, IDLE_R, IDLE_R, IDLE_R, IDLE_R};
    foreach (rows[i]) begin
      cycle(rows[i]);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL cancel_coin row %0d: got %h exp %h", i, dut_v, exp_v());
      end
      if (coin_reject) n_rej++;
      if (change_pulse) n_pulse++;
    end
    checks++;
    if (n_rej != 1 || n_pulse != 6 || monto !== '0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL cancel_totals: got rej=%0d pulses=%0d monto=%0d st=%0d exp 1 6 0 0",
               n_rej, n_pulse, monto, state_dbg);
    end
    // Coin with enable low is refused and leaves the credit alone.
    rows = '{8'b1_01_1_00_0_0, 8'b1_10_0_00_0_0};
    foreach (rows[i]) begin
      cycle(rows[i]);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL enable_off row %0d: got %h exp %h", i, dut_v, exp_v());
      end
    end
    checks++;
    if (coin_reject !== 1'b1 || monto !== 12'd50) begin
      errors++; $display("FAIL enable_off_total: got rej=%b monto=%0d exp 1 50", coin_reject, monto);
    end
    // buy/cancel still work with enable low: refund the 50.
    rows = '{8'b0_00_0_00_0_1, IDLE_R, IDLE_R, IDLE_R};
    foreach (rows[i]) begin
      cycle(rows[i]);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL cancel_enable_off row %0d: got %h exp %h", i, dut_v, exp_v());
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] rows[$];
    int n_pulse = 0;
    rows = '{8'b1_10_1_00_0_0, 8'b1_10_1_00_0_0, 8'b1_10_1_00_0_0,
             8'b0_00_1_00_1_0, IDLE_R, IDLE_R, IDLE_R};
    foreach (rows[i]) begin
      cycle(rows[i]);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL abort row %0d: got %h exp %h", i, dut_v, exp_v());
      end
    end
    // Mid-payout (monto 175, 2nd pulse) reset lands between edges.
    rst = 1'b1;
    model_reset();
    #2;
    checks++;
    if (dut_v !== '0) begin
      errors++; $display("FAIL abort_async: got %h exp %h", dut_v, {(W+7){1'b0}});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(IDLE_R);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL abort_after cyc %0d: got %h exp %h", i, dut_v, exp_v());
      end
      if (change_pulse) n_pulse++;
    end
    cycle(8'b1_01_1_00_0_0);
    checks++;
    if (n_pulse != 0 || monto !== 12'd50 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_resume: got pulses=%0d monto=%0d busy=%b exp 0 50 0", n_pulse, monto, busy);
    end
    cycle(8'b0_00_1_00_0_1);
    repeat (3) cycle(IDLE_R);
  endtask

  task automatic test_random();
    logic [7:0] r;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 500; i++) begin
      r[7]   = ($urandom_range(0, 9) < 4);
      r[6:5] = 2'($urandom_range(0, 3));
      r[4]   = ($urandom_range(0, 9) < 8);
      r[3:2] = 2'($urandom_range(0, 3));
      r[1]   = ($urandom_range(0, 19) < 2);
      r[0]   = ($urandom_range(0, 39) == 0);
      cycle(r);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL random cyc %0d stim %b: got %h exp %h", i, r, dut_v, exp_v());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; enable = 1'b0; coin_valid = 1'b0; buy = 1'b0; cancel = 1'b0;
    moneda = 2'b00; sel = 2'b00;
    test_reset();
    test_coins();
    test_buy_change();
    test_insufficient();
    test_ceiling();
    test_cancel_coin();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/coin_credit_fsm.md
Name: coin_credit_fsm

Overview:
Parametrised successor to the team's single-channel coin adder, for the vending datapath. Accepts four coin denominations on a strobed input and accumulates credit up to a ceiling. A product is selected from four priced slots. The block dispenses on a purchase request and returns change one unit-coin per cycle. Sits between the coin-slot decoder and the product/change actuator drivers.

Parameters:
W, 12, width of credit register and monto output
COIN_V0, 25, value of coin code 2'b00
COIN_V1, 50, value of coin code 2'b01
COIN_V2, 100, value of coin code 2'b10
COIN_V3, 500, value of coin code 2'b11
PRICE0..PRICE3, 75/150/300/1000, price of product selected by sel 0..3
CHANGE_UNIT, 25, value returned per change_pulse; all COIN_Vx and PRICEx are integer multiples of it
MAX_CREDIT, 2000, credit ceiling; must be <= 2^W-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
enable  in  1  coin acceptance enable
coin_valid  in  1  one-cycle strobe, a coin is present on moneda
moneda  in  2  coin code, valid with coin_valid
sel  in  2  product select, sampled with buy
buy  in  1  one-cycle purchase request
cancel  in  1  one-cycle refund request
monto  out  W  current credit
dispense  out  1  one-cycle product release pulse
change_pulse  out  1  one-cycle pulse; release one CHANGE_UNIT coin
coin_reject  out  1  one-cycle pulse; coin not accepted, return it
insufficient  out  1  one-cycle pulse; buy refused, credit < price
busy  out  1  high in DISPENSE or CHANGE

Behaviour:
- Reset, async: state=IDLE, monto=0, all pulse outputs 0, busy=0.
- States: IDLE (credit 0), ACCUM (credit>0), DISPENSE, CHANGE. All outputs are registered, with one-cycle latency from the input edge.
- Coin in IDLE/ACCUM, enable=1, no buy/cancel in the same cycle:
  - If monto + value(moneda) <= MAX_CREDIT: add the value at the next edge and go to ACCUM.
  - Otherwise: credit unchanged, coin_reject=1 for one cycle.
- Coin with enable=0, in DISPENSE/CHANGE, or coincident with buy/cancel: coin_reject=1, credit unchanged.
- Input priority within a cycle: cancel > buy > coin.
- buy in ACCUM with monto >= PRICE[sel]:
  - Next cycle: state DISPENSE, dispense=1, monto = monto - PRICE[sel].
  - Following cycle: CHANGE if remainder > 0, else IDLE.
- buy in ACCUM with monto < PRICE[sel], or buy in IDLE: insufficient=1 for one cycle, state and credit unchanged.
- cancel in ACCUM: go to CHANGE with full credit. cancel in IDLE: no effect.
- CHANGE: each cycle change_pulse=1 and monto -= CHANGE_UNIT. When monto reaches 0, go to IDLE in the same edge; no extra pulse.
  - Exactly monto/CHANGE_UNIT pulses, back-to-back.
- buy and cancel are ignored while busy=1, with no insufficient pulse.
- monto never exceeds MAX_CREDIT and never wraps below 0. Arithmetic is unsigned, W bits.
- rst during DISPENSE/CHANGE aborts immediately: outputs go to reset values and the remaining change is lost.
- enable only gates coins. buy and cancel work with enable=0.

Test Plan:
All scenarios use the default parameters.
- Reset then coins 01,01,01,10 (one per 2 cycles) -> monto 50,100,150,250; no coin_reject; state ACCUM.
- Credit 250, sel=1, buy -> dispense one cycle, monto 100, then 4 consecutive change_pulse (75,50,25,0), busy high for 5 cycles, then IDLE.
- Credit 100, sel=2, buy -> insufficient one cycle, monto stays 100, no dispense.
- Credit 1900, coin 11 (500) -> coin_reject, monto 1900. Then coin 10 -> monto 2000 accepted.
- Credit 150, cancel and coin 00 in the same cycle -> coin_reject=1, 6 change_pulse, monto 0, IDLE. Repeat with enable=0 and a coin only -> coin_reject, credit unchanged.
- Credit 300, sel=0 buy, assert rst on the 2nd change cycle -> monto=0, busy=0, no further change_pulse. Then coin 01 -> monto 50.
